// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton conditioner.
// Holds the auto-repeat state encoding and the helpers that size the
// per-channel counters from their terminal counts.
package button_pkg;

  // Auto-repeat engine states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to count 0 .. n-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Widths at the default 50 MHz timing
  localparam int unsigned DEF_DEBOUNCE_W = cnt_width(1000000);
  localparam int unsigned DEF_REPEAT_W   = cnt_width(max_u(25000000, 5000000));

endpackage

// File: rtl/button_channel.sv
// One pushbutton slice: 2-flop synchronizer, polarity normalization,
// counter debounce, press/release strobes and the auto-repeat engine.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   en             pulse enable; 0 suppresses every strobe and idles repeat
//   raw            asynchronous button pin
//   pressed        debounced level, 1 = held
//   press_pulse    one-cycle strobe on accepted press
//   release_pulse  one-cycle strobe on accepted release
//   action_pulse   press strobe or auto-repeat tick
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic action_pulse
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RP_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
  // Raw pin level when the button is not pressed
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  logic            s1, s2;
  logic            norm_c;
  logic            stable;
  logic [DB_W-1:0] db_cnt;
  logic            rise_c, fall_c;

  rpt_state_e      state, state_nxt;
  logic [RP_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic            tick_c;

  // Synchronizer; resets to the idle pin level so no false press appears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_LVL;
      s2 <= IDLE_LVL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign norm_c = s2 ^ IDLE_LVL;

  // Debounce: accept a new level only after it holds for DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (norm_c == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      stable <= norm_c;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // pressed lags stable by one cycle, so their difference marks the edge
  assign rise_c = stable & ~pressed;
  assign fall_c = ~stable & pressed;

  // Repeat engine state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  // Repeat engine next state; release or en=0 always wins without a tick
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    tick_c      = 1'b0;
    if (!en || fall_c) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_c) begin
            state_nxt   = DELAY;
            rpt_cnt_nxt = '0;
          end
        end
        DELAY: begin
          if (rpt_cnt == RP_W'(REPEAT_DELAY - 1)) begin
            tick_c      = 1'b1;
            state_nxt   = REPEAT;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RP_W'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt == RP_W'(REPEAT_RATE - 1)) begin
            tick_c      = 1'b1;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RP_W'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs; ticks only occur outside IDLE so never meet a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      action_pulse  <= 1'b0;
    end else begin
      pressed       <= stable;
      press_pulse   <= en & rise_c;
      release_pulse <= en & fall_c;
      action_pulse  <= (en & rise_c) | tick_c;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw pushbuttons for the character display block.
// Every channel is an independent button_channel slice sharing clk/en.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   en             pulse enable for all channels
//   buttons_raw    asynchronous pushbutton pins
//   pressed        debounced levels, 1 = held
//   press_pulse    one-cycle strobes on accepted press
//   release_pulse  one-cycle strobes on accepted release
//   action_pulse   press strobe or auto-repeat tick per channel
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 3,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] action_pulse
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .en            (en),
      .raw           (buttons_raw[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .action_pulse  (action_pulse[i])
    );
  end

endmodule
